// File: rtl/attn_weighted_sum_if.sv
// attn_weighted_sum_if: start/busy/done handshake and flat P, V, O buses
// shared between the softmax reader and its controller.
interface attn_weighted_sum_if #(
  parameter int PROB_WIDTH = 32,
  parameter int VAL_WIDTH  = 32,
  parameter int OUT_WIDTH  = 32,
  parameter int SEQ_LEN    = 64,
  parameter int D_HEAD     = 8
);
  logic                                  start;
  logic [PROB_WIDTH*SEQ_LEN*SEQ_LEN-1:0] probs_flat;
  logic [VAL_WIDTH*SEQ_LEN*D_HEAD-1:0]   v_flat;
  logic                                  busy;
  logic                                  done;
  logic [OUT_WIDTH*SEQ_LEN*D_HEAD-1:0]   out_flat;
  logic                                  rowsum_err;

  modport master (
    output start, probs_flat, v_flat,
    input  busy, done, out_flat, rowsum_err
  );

  modport slave (
    input  start, probs_flat, v_flat,
    output busy, done, out_flat, rowsum_err
  );
endinterface

// File: rtl/attn_weighted_sum.sv
// attn_weighted_sum: O = P*V, PARALLEL MACs per cycle, saturated output.
// Optional row-sum check of P enabled by ATTN_ROWSUM_CHECK_EN.
module attn_weighted_sum #(
  parameter int PROB_WIDTH = 32,
  parameter int VAL_WIDTH  = 32,
  parameter int OUT_WIDTH  = 32,
  parameter int SEQ_LEN    = 64,
  parameter int D_HEAD     = 8,
  parameter int FRAC_BITS  = 8,
  parameter int PARALLEL   = 8,
  parameter int ROWSUM_TOL = 16
) (
  input logic                clk,
  input logic                rst_n,
  attn_weighted_sum_if.slave bus
);
  localparam int LSEQ = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int IW   = LSEQ;
  localparam int DW   = (D_HEAD > 1) ? $clog2(D_HEAD) : 1;
  localparam int AW   = PROB_WIDTH + VAL_WIDTH + $clog2(SEQ_LEN) + 1;
  localparam int NP   = SEQ_LEN * SEQ_LEN;
  localparam int NV   = SEQ_LEN * D_HEAD;
  localparam int PIW  = (NP > 1) ? $clog2(NP) : 1;
  localparam int VIW  = (NV > 1) ? $clog2(NV) : 1;

  localparam logic signed [AW-1:0] SAT_MAX =
    {{(AW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN =
    {{(AW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [IW-1:0]         r_i;
  logic [DW-1:0]         r_d;
  logic [IW-1:0]         r_j;
  logic signed [AW-1:0]  r_acc;
  logic                  r_done;
  logic [OUT_WIDTH-1:0]  r_out [NV];

  logic [PROB_WIDTH-1:0] w_p [NP];
  logic [VAL_WIDTH-1:0]  w_v [NV];
  logic signed [AW-1:0]  w_sum;
  logic signed [AW-1:0]  w_shf;
  logic [OUT_WIDTH-1:0]  w_sat;
  logic [VIW-1:0]        w_eidx;
  logic                  w_jlast;
  logic                  w_dlast;
  logic                  w_ilast;
  logic                  w_start;

`ifdef ATTN_ROWSUM_CHECK_EN
  localparam int RSW = PROB_WIDTH + LSEQ;
  localparam logic signed [RSW:0] RS_ONE = (RSW+1)'(2**FRAC_BITS);
  localparam logic [RSW:0]        RS_TOL = (RSW+1)'(ROWSUM_TOL);

  logic [RSW-1:0]        r_rsum;
  logic                  r_err;
  logic [RSW-1:0]        w_psum;
  logic signed [RSW:0]   w_dev;
  logic [RSW:0]          w_abs;
  logic                  w_bad;
`endif

  // unpack flat buses into word arrays
  for (genvar g = 0; g < NP; g++) begin : g_p
    assign w_p[g] = bus.probs_flat[g*PROB_WIDTH +: PROB_WIDTH];
  end
  for (genvar g = 0; g < NV; g++) begin : g_v
    assign w_v[g] = bus.v_flat[g*VAL_WIDTH +: VAL_WIDTH];
  end
  for (genvar g = 0; g < NV; g++) begin : g_o
    assign bus.out_flat[g*OUT_WIDTH +: OUT_WIDTH] = r_out[g];
  end

  assign w_start = (r_state == S_IDLE) && bus.start;
  assign w_jlast = (int'(r_j) + PARALLEL) >= SEQ_LEN;
  assign w_dlast = int'(r_d) == (D_HEAD - 1);
  assign w_ilast = int'(r_i) == (SEQ_LEN - 1);
  assign w_eidx  = VIW'(int'(r_i) * D_HEAD + int'(r_d));
  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = r_done;

  // MAC lanes; lanes past the last row of V are masked to zero
  always_comb begin
    w_sum = '0;
`ifdef ATTN_ROWSUM_CHECK_EN
    w_psum = '0;
`endif
    for (int p = 0; p < PARALLEL; p++) begin
      logic                  lv;
      int                    jj;
      logic [PROB_WIDTH-1:0] pv;
      logic [VAL_WIDTH-1:0]  vv;
      logic signed [AW-1:0]  pe;
      logic signed [AW-1:0]  ve;
      lv = (int'(r_j) + p) < SEQ_LEN;
      jj = lv ? (int'(r_j) + p) : 0;
      pv = w_p[PIW'(int'(r_i) * SEQ_LEN + jj)];
      vv = w_v[VIW'(jj * D_HEAD + int'(r_d))];
      pe = lv ? AW'($signed({1'b0, pv})) : '0;
      ve = AW'($signed(vv));
      w_sum = w_sum + pe * ve;
`ifdef ATTN_ROWSUM_CHECK_EN
      w_psum = w_psum + (lv ? RSW'(pv) : '0);
`endif
    end
  end

  // rescale the accumulator and clamp it to the output range
  always_comb begin
    w_shf = r_acc >>> FRAC_BITS;
    if (w_shf > SAT_MAX) begin
      w_sat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else if (w_shf < SAT_MIN) begin
      w_sat = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      w_sat = w_shf[OUT_WIDTH-1:0];
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_next = S_MAC;
      S_MAC:   if (w_jlast) w_next = S_WRITE;
      S_WRITE: w_next = (w_ilast && w_dlast) ? S_DONE : S_MAC;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // indices, accumulator and output element registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i   <= '0;
      r_d   <= '0;
      r_j   <= '0;
      r_acc <= '0;
      for (int e = 0; e < NV; e++) begin
        r_out[e] <= '0;
      end
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_i   <= '0;
            r_d   <= '0;
            r_j   <= '0;
            r_acc <= '0;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + w_sum;
          r_j   <= w_jlast ? '0 : r_j + IW'(PARALLEL);
        end
        S_WRITE: begin
          r_out[w_eidx] <= w_sat;
          r_acc         <= '0;
          if (w_dlast) begin
            r_d <= '0;
            r_i <= w_ilast ? '0 : r_i + IW'(1);
          end else begin
            r_d <= r_d + DW'(1);
          end
        end
        S_DONE: begin
          r_j <= '0;
        end
        default: begin
          r_j <= '0;
        end
      endcase
    end
  end

  // one-cycle completion pulse, raised as the FSM leaves DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
    end
  end

`ifdef ATTN_ROWSUM_CHECK_EN
  // distance of the row sum from 1.0
  always_comb begin
    w_dev = $signed({1'b0, r_rsum}) - RS_ONE;
    w_abs = w_dev[RSW] ? $unsigned(-w_dev) : $unsigned(w_dev);
    w_bad = w_abs > RS_TOL;
  end

  // row sum gathered on the d==0 pass; error flag is sticky
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsum <= '0;
      r_err  <= 1'b0;
    end else if (w_start) begin
      r_rsum <= '0;
      r_err  <= 1'b0;
    end else if (r_d == '0) begin
      if (r_state == S_MAC) begin
        r_rsum <= r_rsum + w_psum;
      end else if (r_state == S_WRITE) begin
        r_rsum <= '0;
        if (w_bad) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign bus.rowsum_err = r_err;
`else
  assign bus.rowsum_err = 1'b0;
`endif
endmodule

// File: tb/tb_attn_weighted_sum.sv
// tb_attn_weighted_sum: directed vectors on two instances
// (PARALLEL=2/OUT=32 and PARALLEL=3/OUT=16) sharing the P and V buses.
module tb_attn_weighted_sum;
  localparam int SL = 4;
  localparam int DH = 2;
  localparam int PW = 32;
  localparam int VW = 32;
  localparam int FB = 8;
  localparam int LAT = 25;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  attn_weighted_sum_if #(.PROB_WIDTH(PW), .VAL_WIDTH(VW), .OUT_WIDTH(32),
    .SEQ_LEN(SL), .D_HEAD(DH)) if0 ();
  attn_weighted_sum_if #(.PROB_WIDTH(PW), .VAL_WIDTH(VW), .OUT_WIDTH(16),
    .SEQ_LEN(SL), .D_HEAD(DH)) if1 ();

  attn_weighted_sum #(.PROB_WIDTH(PW), .VAL_WIDTH(VW), .OUT_WIDTH(32),
    .SEQ_LEN(SL), .D_HEAD(DH), .FRAC_BITS(FB), .PARALLEL(2),
    .ROWSUM_TOL(16)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));

  attn_weighted_sum #(.PROB_WIDTH(PW), .VAL_WIDTH(VW), .OUT_WIDTH(16),
    .SEQ_LEN(SL), .D_HEAD(DH), .FRAC_BITS(FB), .PARALLEL(3),
    .ROWSUM_TOL(16)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  logic [PW*SL*SL-1:0] p_flat;
  logic [VW*SL*DH-1:0] v_flat;
  assign if0.probs_flat = p_flat;
  assign if0.v_flat     = v_flat;
  assign if1.probs_flat = p_flat;
  assign if1.v_flat     = v_flat;

  typedef struct {
    string name;
    int    p   [16];
    int    v   [8];
    int    e32 [8];
    int    e16 [8];
  } vec_t;

  vec_t tbl [6];
  int   P [16];
  int   V [8];
  int   E32 [8];
  int   E16 [8];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic pack();
    for (int k = 0; k < 16; k++) p_flat[k*PW +: PW] = P[k];
    for (int k = 0; k < 8; k++) v_flat[k*VW +: VW] = V[k];
  endtask

  task automatic check_out(input string tag, input bit do0, input bit do1);
    logic signed [31:0] a32;
    logic signed [15:0] a16;
    for (int e = 0; e < 8; e++) begin
      a32 = if0.out_flat[e*32 +: 32];
      a16 = if1.out_flat[e*16 +: 16];
      if (do0) chk($sformatf("%s_u0_o%0d", tag, e), int'(a32), E32[e]);
      if (do1) chk($sformatf("%s_u1_o%0d", tag, e), int'(a16), E16[e]);
    end
  endtask

  // start selected instances, optionally re-pulse u1 start at edge pulse_at
  task automatic run(input bit go0, input bit go1, input int pulse_at,
                     output int lat0, output int lat1,
                     output bit busy_ok, output bit twice,
                     output bit err0_at_done);
    @(negedge clk);
    if0.start = go0;
    if1.start = go1;
    @(posedge clk);
    lat0 = -1;
    lat1 = -1;
    busy_ok = 1'b1;
    err0_at_done = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if0.start = 1'b0;
      if1.start = (n == pulse_at);
      @(posedge clk);
      #1;
      if (go0 && lat0 < 0) begin
        if (if0.done) begin
          lat0 = n;
          err0_at_done = if0.rowsum_err;
        end else if (!if0.busy) busy_ok = 1'b0;
      end
      if (go1 && lat1 < 0) begin
        if (if1.done) lat1 = n;
        else if (!if1.busy) busy_ok = 1'b0;
      end
      if ((!go0 || lat0 >= 0) && (!go1 || lat1 >= 0)) break;
    end
    if1.start = 1'b0;
    @(posedge clk);
    #1;
    twice = (go0 && if0.done) || (go1 && if1.done);
  endtask

  task automatic set_uniform(input int row0);
    for (int k = 0; k < 16; k++) P[k] = (k < 4) ? row0 : 64;
    V = '{256, 0, 512, 0, 768, 0, 1024, 0};
    for (int e = 0; e < 8; e++) begin
      E32[e] = (e % 2 == 0) ? ((e == 0) ? row0 * 10 : 640) : 0;
      E16[e] = E32[e];
    end
    pack();
  endtask

  int lat0, lat1;
  bit bok, twice, edone;

  initial begin
    if0.start = 1'b0;
    if1.start = 1'b0;
    p_flat = '0;
    v_flat = '0;

    tbl[0].name = "uniform";
    tbl[0].p    = '{default: 64};
    tbl[0].v    = '{256, 0, 512, 0, 768, 0, 1024, 0};
    tbl[0].e32  = '{640, 0, 640, 0, 640, 0, 640, 0};
    tbl[0].e16  = '{640, 0, 640, 0, 640, 0, 640, 0};
    tbl[1].name = "onehot";
    tbl[1].p    = '{256, 0, 0, 0, 0, 256, 0, 0,
                    0, 0, 256, 0, 0, 0, 0, 256};
    tbl[1].v    = '{-300, 77, 1234, -5, 0, -2048, 999, 13};
    tbl[1].e32  = '{-300, 77, 1234, -5, 0, -2048, 999, 13};
    tbl[1].e16  = '{-300, 77, 1234, -5, 0, -2048, 999, 13};
    tbl[2].name = "round";
    tbl[2].p    = '{128, 128, 0, 0, 0, 0, 0, 0,
                    0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2].v    = '{-512, 0, 256, 0, 0, 0, 0, 0};
    tbl[2].e32  = '{-128, 0, 0, 0, 0, 0, 0, 0};
    tbl[2].e16  = '{-128, 0, 0, 0, 0, 0, 0, 0};
    tbl[3].name = "floor";
    tbl[3].p    = '{1, 0, 0, 0, 1, 0, 0, 0,
                    0, 0, 0, 0, 0, 0, 0, 0};
    tbl[3].v    = '{-1, 1, 0, 0, 0, 0, 0, 0};
    tbl[3].e32  = '{-1, 0, -1, 0, 0, 0, 0, 0};
    tbl[3].e16  = '{-1, 0, -1, 0, 0, 0, 0, 0};
    tbl[4].name = "sat_pos";
    tbl[4].p    = '{default: 256};
    tbl[4].v    = '{default: 30000};
    tbl[4].e32  = '{default: 120000};
    tbl[4].e16  = '{default: 32767};
    tbl[5].name = "sat_neg";
    tbl[5].p    = '{default: 256};
    tbl[5].v    = '{default: -30000};
    tbl[5].e32  = '{default: -120000};
    tbl[5].e16  = '{default: -32768};

    // reset state
    #2;
    chk("rst_busy0", int'(if0.busy), 0);
    chk("rst_done0", int'(if0.done), 0);
    chk("rst_out0", int'(if0.out_flat == '0), 1);
    chk("rst_err0", int'(if0.rowsum_err), 0);
    chk("rst_busy1", int'(if1.busy), 0);
    chk("rst_done1", int'(if1.done), 0);
    chk("rst_out1", int'(if1.out_flat == '0), 1);
    chk("rst_err1", int'(if1.rowsum_err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven vectors on both instances
    for (int t = 0; t < 6; t++) begin
      P   = tbl[t].p;
      V   = tbl[t].v;
      E32 = tbl[t].e32;
      E16 = tbl[t].e16;
      pack();
      run(1'b1, 1'b1, 0, lat0, lat1, bok, twice, edone);
      chk({tbl[t].name, "_lat0"}, lat0, LAT);
      chk({tbl[t].name, "_lat1"}, lat1, LAT);
      chk({tbl[t].name, "_busy"}, int'(bok), 1);
      chk({tbl[t].name, "_done_once"}, int'(twice), 0);
      check_out(tbl[t].name, 1'b1, 1'b1);
    end

`ifndef ATTN_ROWSUM_CHECK_EN
    chk("rowsum_tied0", int'(if0.rowsum_err), 0);
`endif

    // start pulsed mid-run is ignored
    set_uniform(64);
    run(1'b0, 1'b1, 10, lat0, lat1, bok, twice, edone);
    chk("midstart_lat", lat1, LAT);
    chk("midstart_busy", int'(bok), 1);
    check_out("midstart", 1'b0, 1'b1);

    // asynchronous reset mid-run
    @(negedge clk);
    if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    chk("pre_rst_busy", int'(if1.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(if1.busy), 0);
    chk("arst_done", int'(if1.done), 0);
    chk("arst_out", int'(if1.out_flat == '0), 1);
    @(negedge clk);
    rst_n = 1'b1;
    run(1'b0, 1'b1, 0, lat0, lat1, bok, twice, edone);
    chk("post_rst_lat", lat1, LAT);
    check_out("post_rst", 1'b0, 1'b1);

`ifdef ATTN_ROWSUM_CHECK_EN
    set_uniform(64);
    run(1'b1, 1'b0, 0, lat0, lat1, bok, twice, edone);
    chk("rs_ok_err", int'(if0.rowsum_err), 0);
    set_uniform(80);
    run(1'b1, 1'b0, 0, lat0, lat1, bok, twice, edone);
    chk("rs_bad_lat", lat0, LAT);
    chk("rs_bad_at_done", int'(edone), 1);
    chk("rs_bad_after", int'(if0.rowsum_err), 1);
    check_out("rs_bad", 1'b1, 1'b0);
    set_uniform(64);
    run(1'b1, 1'b0, 0, lat0, lat1, bok, twice, edone);
    chk("rs_cleared", int'(if0.rowsum_err), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/attn_weighted_sum.md
Name: attn_weighted_sum

Overview:
- Reader/consumer of the softmax stage output. After the softmax block signals done, this block reads the probability matrix P[SEQ_LEN][SEQ_LEN] and the value matrix V[SEQ_LEN][D_HEAD].
- It computes the attention output O = P·V, one output element at a time, processing PARALLEL products per cycle.
- It uses the same start/done, flat-bus, fixed-point (FRAC_BITS) conventions as the softmax stage.

Parameters:
- PROB_WIDTH, 32, width of each probability word; unsigned fixed point, FRAC_BITS fraction bits (256 = 1.0).
- VAL_WIDTH, 32, width of each V element; signed, FRAC_BITS fraction bits.
- OUT_WIDTH, 32, width of each O element; signed, saturated.
- SEQ_LEN, 64, sequence length (rows of P and V).
- D_HEAD, 8, head dimension (columns of V and O).
- FRAC_BITS, 8, fraction bits shared by P, V and O.
- PARALLEL, 8, MAC lanes per cycle; need not divide SEQ_LEN.
- ROWSUM_TOL, 16, row-sum tolerance in LSBs (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- probs_flat  in  PROB_WIDTH*SEQ_LEN*SEQ_LEN  P; element (i,j) at bit offset (i*SEQ_LEN+j)*PROB_WIDTH.
- v_flat  in  VAL_WIDTH*SEQ_LEN*D_HEAD  V; element (j,d) at bit offset (j*D_HEAD+d)*VAL_WIDTH.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- out_flat  out  OUT_WIDTH*SEQ_LEN*D_HEAD  O; element (i,d) at bit offset (i*D_HEAD+d)*OUT_WIDTH.
- rowsum_err  out  1  sticky row-sum error flag (optional feature; tied 0 otherwise).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; busy=0, done=0, rowsum_err=0.
  - out_flat all zero; indices and accumulator cleared.
  - Reset asserted mid-run aborts the run immediately to this same state.
- States: IDLE, MAC, WRITE, DONE.
- IDLE:
  - start=1 → clear i, d, j and acc; go to MAC.
  - start=0 → stay in IDLE.
- MAC:
  - Each cycle, acc += sum over p in [0,PARALLEL) of P[i][j+p]*V[j+p][d].
  - Lanes with j+p >= SEQ_LEN contribute 0 and must not index out of range.
  - If j+PARALLEL >= SEQ_LEN: set j=0, go to WRITE. Otherwise j += PARALLEL.
  - K = ceil(SEQ_LEN/PARALLEL) MAC cycles per output element.
- WRITE:
  - Writes O[i][d] = sat(acc >>> FRAC_BITS) and clears acc.
  - Advances d; when d wraps, advances i.
  - After element (SEQ_LEN-1, D_HEAD-1), go to DONE; otherwise return to MAC.
- DONE: done<=1 for exactly one cycle; state<=IDLE.
- Arithmetic:
  - P is zero-extended; V is signed; products are signed.
  - acc width = PROB_WIDTH+VAL_WIDTH+$clog2(SEQ_LEN)+1, signed; it must never overflow.
  - The shift is arithmetic (rounds toward −inf).
  - Saturation range is [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1].
- Latency:
  - N = SEQ_LEN*D_HEAD elements.
  - done rises N*(K+1)+1 rising edges after the edge that samples start.
  - busy is high from the first edge after start through the DONE cycle.
- Ordering and output stability:
  - Elements are written in row-major order (i outer, d inner).
  - Each out_flat element is stable between its own WRITE cycles.
  - A new start does not clear out_flat; elements are overwritten as the run progresses.
- Input contract: probs_flat and v_flat must be held stable from the start edge until done. Inputs are not latched.
- Boundary conditions:
  - start while busy is ignored, with no effect on state or counters.
  - start in the cycle done=1 is accepted (state is IDLE); done falls on the next edge.
  - SEQ_LEN < PARALLEL is legal: K=1.

Optional Feature:
- Macro: ATTN_ROWSUM_CHECK_EN.
- Defined:
  - During the d==0 pass of each row, sum the valid P lanes into rsum (width PROB_WIDTH+$clog2(SEQ_LEN)).
  - At that WRITE, if |rsum − 2^FRAC_BITS| > ROWSUM_TOL, set rowsum_err.
  - rowsum_err is sticky; cleared by reset or an accepted start.
  - Timing and outputs are otherwise unchanged.
- Undefined: no rsum logic; rowsum_err tied to 0.

Test Plan:
- Bench config for all scenarios: SEQ_LEN=4, D_HEAD=2, PARALLEL=2, FRAC_BITS=8 (K=2, N=8).
1. Uniform rows: every P=64 (0.25); V[:,0]={256,512,768,1024}, V[:,1]=0 → O[i][0]=640, O[i][1]=0 for all i. busy=1 throughout; done pulses exactly once, 25 edges after the start edge.
2. One-hot rows: P[i][i]=256, others 0; V random signed → O equals V exactly.
3. Signed rounding: P row0={128,128,0,0}; V[:,0]={−512,256,0,0} → O[0][0]=−128. Row {1,0,0,0} with V[0][0]=−1 → O[0][0]=−1 (floor).
4. Saturation with OUT_WIDTH=16: all P=256 and all V=30000 → every O=32767. All V=−30000 → every O=−32768.
5. Control with PARALLEL=3 (lane masking): scenario 1 data gives identical results.
   - start pulsed mid-run → ignored, done still at edge 25.
   - rst_n low mid-run → busy=0, done=0, out_flat=0 immediately; a fresh start then completes normally.
6. With ATTN_ROWSUM_CHECK_EN defined, scenario 1 → rowsum_err=0. Row0 all P=80 (sum 320) → rowsum_err=1, stays 1 through done, cleared by the next start.
